datapath_seq: RTL and testbench
===============================

// Module: datapath_seq
// PURPOSE
//  Parametrised, self-sequencing datapath: register file, A/B operand regs, shifter, ALU, C result reg, status reg.
//  Internal FSM replaces the external load strobes (loada/loadb/loadc/loads/vsel/asel/bsel).
//  The host issues one command per start/done handshake. Sits between the instruction controller and memory/IO.
// PARAMETERS
//  WIDTH  16  datapath word width (>=4)
//  NREGS  8   register count (power of 2, >=2); localparam RAW = $clog2(NREGS)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      command request; accepted only when busy=0
//  cmd          in   2      00 MOVI, 01 ALU, 10 CMP, 11 MOV
//  rd,rn,rm     in   RAW    destination, A-source, B-source register
//  shift        in   2      00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
//  alu_op       in   2      00 ADD, 01 SUB, 10 AND, 11 NOT B
//  datapath_in  in   WIDTH  immediate for MOVI
//  busy         out  1      FSM not in IDLE
//  done         out  1      one-cycle completion pulse
//  datapath_out out  WIDTH  C register
//  Z_out,N_out,V_out out 1  status register
//  dbg_readnum  in   RAW    debug read address
//  dbg_data     out  WIDTH  combinational R[dbg_readnum]
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; all R[i], A, B, C, status cleared to 0; busy=0; done=0.
//  Reset mid-command aborts it; no partial writeback survives.
//  Accept edge k: start=1 in IDLE; cmd, rd, rn, rm, shift, alu_op, datapath_in latched.
//  start is ignored while busy=1. It is accepted in the same cycle that done=1 (FSM is IDLE).
//  States: IDLE, LDA, LDB, EXEC, WB.
//  MOVI: IDLE->WB. Edge k+1: R[rd]<=latched datapath_in; done=1 in cycle k+1..k+2. A, B, C and status unchanged.
//  ALU:  IDLE->LDA->LDB->EXEC->WB.
//    k+1: A<=R[rn]. k+2: B<=R[rm]. k+3: C<=A op sh(B), status updated. k+4: R[rd]<=C, done.
//  CMP:  LDA->LDB->EXEC. Forces SUB; updates status only (C unchanged); done after k+3; no writeback.
//  MOV:  LDB->EXEC->WB. A is treated as 0, ADD is forced. C<=sh(R[rm]) at k+2; R[rd] written at k+3; done.
//  busy = (state!=IDLE). done is registered, high exactly 1 cycle, in the cycle the FSM re-enters IDLE.
//  Arithmetic: modulo 2^WIDTH. ASR replicates bit WIDTH-1. LSR/LSL shift in 0.
//  Flags, updated at every EXEC:
//    Z = (result==0); N = result[WIDTH-1]
//    V = signed overflow for ADD/SUB, 0 for AND/NOT
//  rd==rn/rm is legal: operands are captured before writeback.
//  A following command reads the updated value, because writeback precedes done.
//  Single write port. The FSM is the only writer.
// STRUCTURE
//  datapath_pkg: cmd/alu_op/shift encodings, FSM state encoding.
//  Sub-module datapath_regfile:
//    NREGS x WIDTH, async-clear, 1 write port, 3 comb read ports (rn, rm, dbg).
//  Top module: FSM, A/B/C/status regs, shifter and ALU (combinational).
// TESTING
//  Run at WIDTH=16, NREGS=8 unless noted.
//  1 MOVI R0=7; MOVI R1=2; ALU rd=R2 rn=R1 rm=R0 LSL1 ADD
//    -> datapath_out=0x0010, R2=0x0010, Z=0, done at k+4, busy high 4 cycles.
//  2 CMP rn=R0 rm=R0 -> Z=1 N=0 V=0; done at k+3; datapath_out and all R unchanged.
//  3 R3=0x7FFF, R4=0x0001, ALU ADD -> R5=0x8000, N=1, V=1, Z=0.
//  4 R6=0x8000; MOV rm=R6 ASR1 rd=R7 -> R7=0xC000, done at k+3; then LSR1 -> 0x4000.
//  5 start pulsed during busy -> ignored; start held through done -> back-to-back accept.
//    rst_n=0 at k+2 of ALU -> all R=0, busy=0, no done.
//  6 WIDTH=8, NREGS=4: 0x7F + 0x01 -> 0x80, V=1; dbg_data tracks every write.

Source files
------------

// File: rtl/datapath_pkg.sv
// ----------------------------------------------------------------------------
// datapath_pkg
//   Shared encodings for the self-sequencing datapath: host command codes,
//   B-operand shift codes, ALU operation codes and the FSM state encoding.
//   first_state() maps an accepted command to the first non-IDLE state.
// ----------------------------------------------------------------------------
package datapath_pkg;

   typedef enum logic [1:0] {
      CMD_MOVI = 2'b00,
      CMD_ALU  = 2'b01,
      CMD_CMP  = 2'b10,
      CMD_MOV  = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_AND  = 2'b10,
      ALU_NOTB = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LDA  = 3'd1,
      ST_LDB  = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_e;

   // MOVI skips straight to writeback, MOV skips the A load,
   // ALU and CMP walk the full operand-load sequence.
   function automatic state_e first_state(input cmd_e c);
      case (c)
         CMD_MOVI: return ST_WB;
         CMD_MOV:  return ST_LDB;
         default:  return ST_LDA;
      endcase
   endfunction

endpackage

// File: rtl/datapath_regfile.sv
// ----------------------------------------------------------------------------
// datapath_regfile
//   NREGS x WIDTH register file, asynchronously cleared, one synchronous
//   write port and three combinational read ports.
// Ports
//   clk, rst_n            clock, asynchronous active-low clear
//   we, waddr, wdata      write port
//   ra_addr / ra_data     read port A (operand A source)
//   rb_addr / rb_data     read port B (operand B source)
//   rdbg_addr / rdbg_data debug read port
// ----------------------------------------------------------------------------
module datapath_regfile
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int RAW  = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [RAW-1:0]   waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [RAW-1:0]   ra_addr,
   output logic [WIDTH-1:0] ra_data,
   input  logic [RAW-1:0]   rb_addr,
   output logic [WIDTH-1:0] rb_data,
   input  logic [RAW-1:0]   rdbg_addr,
   output logic [WIDTH-1:0] rdbg_data
);

   logic [WIDTH-1:0] words [NREGS];

   // One flop word per register so each gets its own async clear and
   // decoded write enable.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_word
      logic [WIDTH-1:0] word_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            word_q <= '0;
         end else if (we && (waddr == RAW'(gi))) begin
            word_q <= wdata;
         end
      end

      assign words[gi] = word_q;
   end

   assign ra_data   = words[ra_addr];
   assign rb_data   = words[rb_addr];
   assign rdbg_data = words[rdbg_addr];

endmodule

// File: rtl/datapath_seq.sv
// ----------------------------------------------------------------------------
// datapath_seq
//   Self-sequencing datapath: register file, A/B operand registers, B-side
//   shifter, ALU, C result register and Z/N/V status. An internal FSM
//   (IDLE, LDA, LDB, EXEC, WB) walks each host command accepted on a
//   start/done handshake.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 command request, taken only while IDLE
//   cmd                   MOVI / ALU / CMP / MOV
//   rd, rn, rm            destination, A-source, B-source registers
//   shift, alu_op         B shift and ALU operation
//   datapath_in           MOVI immediate
//   busy                  FSM not in IDLE
//   done                  one-cycle completion pulse
//   datapath_out          C register
//   Z_out, N_out, V_out   status register
//   dbg_readnum/dbg_data  combinational debug read of the register file
// ----------------------------------------------------------------------------
module datapath_seq
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int RAW  = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       cmd,
   input  logic [RAW-1:0]   rd,
   input  logic [RAW-1:0]   rn,
   input  logic [RAW-1:0]   rm,
   input  logic [1:0]       shift,
   input  logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] datapath_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] datapath_out,
   output logic             Z_out,
   output logic             N_out,
   output logic             V_out,
   input  logic [RAW-1:0]   dbg_readnum,
   output logic [WIDTH-1:0] dbg_data
);

   state_e           state_q, state_d;
   cmd_e             cmd_q, cmd_d;
   shift_e           shift_q, shift_d;
   alu_op_e          alu_op_q, alu_op_d;
   logic [RAW-1:0]   rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic             z_q, z_d, n_q, n_d, v_q, v_d;
   logic             done_q, done_d;

   logic             rf_we;
   logic [WIDTH-1:0] rf_wdata, ra_data, rb_data;

   logic [WIDTH-1:0] sh_b, op_a, alu_res;
   logic             alu_v;
   alu_op_e          eff_op;

   datapath_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (rf_we),
      .waddr     (rd_q),
      .wdata     (rf_wdata),
      .ra_addr   (rn_q),
      .ra_data   (ra_data),
      .rb_addr   (rm_q),
      .rb_data   (rb_data),
      .rdbg_addr (dbg_readnum),
      .rdbg_data (dbg_data)
   );

   // Shifter on B, then ALU. MOV sees A as zero and always adds; CMP
   // always subtracts.
   always_comb begin
      case (shift_q)
         SH_LSL1: sh_b = {b_q[WIDTH-2:0], 1'b0};
         SH_LSR1: sh_b = {1'b0, b_q[WIDTH-1:1]};
         SH_ASR1: sh_b = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
         default: sh_b = b_q;
      endcase

      op_a   = (cmd_q == CMD_MOV) ? '0 : a_q;
      eff_op = alu_op_q;
      if (cmd_q == CMD_CMP) eff_op = ALU_SUB;
      if (cmd_q == CMD_MOV) eff_op = ALU_ADD;

      alu_res = '0;
      alu_v   = 1'b0;
      case (eff_op)
         ALU_ADD: begin
            alu_res = op_a + sh_b;
            alu_v   = (op_a[WIDTH-1] == sh_b[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = op_a - sh_b;
            alu_v   = (op_a[WIDTH-1] != sh_b[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_AND:  alu_res = op_a & sh_b;
         default:  alu_res = ~sh_b;
      endcase
   end

   // Next-state and datapath load control.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      shift_d  = shift_q;
      alu_op_d = alu_op_q;
      rd_d     = rd_q;
      rn_d     = rn_q;
      rm_d     = rm_q;
      imm_d    = imm_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      done_d   = 1'b0;
      rf_we    = 1'b0;
      rf_wdata = c_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cmd_d    = cmd_e'(cmd);
               shift_d  = shift_e'(shift);
               alu_op_d = alu_op_e'(alu_op);
               rd_d     = rd;
               rn_d     = rn;
               rm_d     = rm;
               imm_d    = datapath_in;
               state_d  = first_state(cmd_e'(cmd));
            end
         end
         ST_LDA: begin
            a_d     = ra_data;
            state_d = ST_LDB;
         end
         ST_LDB: begin
            b_d     = rb_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            z_d = (alu_res == '0);
            n_d = alu_res[WIDTH-1];
            v_d = alu_v;
            if (cmd_q == CMD_CMP) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               c_d     = alu_res;
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            rf_we    = 1'b1;
            rf_wdata = (cmd_q == CMD_MOVI) ? imm_q : c_q;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cmd_q    <= CMD_MOVI;
         shift_q  <= SH_NONE;
         alu_op_q <= ALU_ADD;
         rd_q     <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         shift_q  <= shift_d;
         alu_op_q <= alu_op_d;
         rd_q     <= rd_d;
         rn_q     <= rn_d;
         rm_q     <= rm_d;
         imm_q    <= imm_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         z_q      <= z_d;
         n_q      <= n_d;
         v_q      <= v_d;
         done_q   <= done_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign datapath_out = c_q;
   assign Z_out        = z_q;
   assign N_out        = n_q;
   assign V_out        = v_q;

endmodule

// File: tb/tb_datapath_seq.sv
// ----------------------------------------------------------------------------
// tb_datapath_seq
//   Scoreboard bench for datapath_seq (16-bit/8-reg instance plus an
//   8-bit/4-reg instance). Each issued command pushes its expected C value,
//   flags and accept-to-done latency; a monitor pops on every done pulse.
// ----------------------------------------------------------------------------
module tb_datapath_seq;
   import datapath_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  cmd = '0, shift = '0, alu_op = '0;
   logic [2:0]  rd = '0, rn = '0, rm = '0, dbg_rn = '0;
   logic [15:0] din = '0;
   logic        busy, done, z, n, v;
   logic [15:0] dout, dbg_d;

   logic        start8 = 1'b0;
   logic [1:0]  cmd8 = '0, alu_op8 = '0;
   logic [1:0]  rd8 = '0, rn8 = '0, rm8 = '0, dbg8_rn = '0;
   logic [7:0]  din8 = '0;
   logic        busy8, done8, z8, n8, v8;
   logic [7:0]  dout8, dbg8_d;

   datapath_seq #(.WIDTH(16), .NREGS(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .rd(rd), .rn(rn),
      .rm(rm), .shift(shift), .alu_op(alu_op), .datapath_in(din),
      .busy(busy), .done(done), .datapath_out(dout), .Z_out(z), .N_out(n),
      .V_out(v), .dbg_readnum(dbg_rn), .dbg_data(dbg_d)
   );

   datapath_seq #(.WIDTH(8), .NREGS(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .cmd(cmd8), .rd(rd8),
      .rn(rn8), .rm(rm8), .shift(2'b00), .alu_op(alu_op8),
      .datapath_in(din8), .busy(busy8), .done(done8), .datapath_out(dout8),
      .Z_out(z8), .N_out(n8), .V_out(v8), .dbg_readnum(dbg8_rn),
      .dbg_data(dbg8_d)
   );

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] out;
      logic [2:0]  znv;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Monitor: every done pulse retires the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            $display("txn @%0d: dout=%h znv=%b lat=%0d (want %h %b %0d)",
                     cyc, dout, {z, n, v}, cyc - mon_e.acc,
                     mon_e.out, mon_e.znv, mon_e.lat);
            chk("dout", 32'(dout), 32'(mon_e.out));
            chk("flags", 32'({z, n, v}), 32'(mon_e.znv));
            chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end
   end

   task automatic issue(input logic [1:0] c, input logic [2:0] d, a, b,
                        input logic [1:0] sh, op, input logic [15:0] imm,
                        input logic [15:0] eout, input logic [2:0] eznv,
                        input int elat);
      exp_t e;
      @(posedge clk); #1;
      cmd = c; rd = d; rn = a; rm = b; shift = sh; alu_op = op; din = imm;
      start = 1'b1;
      e.out = eout; e.znv = eznv; e.lat = elat; e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int nbusy);
      bit found = 0;
      nbusy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin found = 1; break; end
         if (busy) nbusy++;
      end
      if (!found) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reg(input logic [2:0] r, input logic [15:0 ] val);
      dbg_rn = r; #1;
      chk($sformatf("R%0d", r), 32'(dbg_d), 32'(val));
   endtask

   task automatic run(input logic [1:0] c, input logic [2:0] d, a, b,
                      input logic [1:0] sh, op, input logic [15:0] imm,
                      input logic [15:0] eout, input logic [2:0] eznv,
                      input int elat, input logic [15:0] ereg);
      int nb;
      issue(c, d, a, b, sh, op, imm, eout, eznv, elat);
      wait_done(nb);
      chk("busy_cycles", 32'(nb), 32'(elat));
      if (c != CMD_CMP) check_reg(d, ereg);
   endtask

   task automatic run8(input logic [1:0] c, input logic [1:0] d, a, b,
                       input logic [1:0] op, input logic [7:0] imm,
                       input logic [7:0] eout, input logic [2:0] eznv,
                       input logic [7:0] ereg);
      bit found = 0;
      @(posedge clk); #1;
      cmd8 = c; rd8 = d; rn8 = a; rm8 = b; alu_op8 = op; din8 = imm;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) begin found = 1; break; end
      end
      chk("w8_done", 32'(found), 32'd1);
      $display("txn8: dout=%h znv=%b", dout8, {z8, n8, v8});
      chk("w8_dout", 32'(dout8), 32'(eout));
      chk("w8_flags", 32'({z8, n8, v8}), 32'(eznv));
      dbg8_rn = d; #1;
      chk("w8_dbg", 32'(dbg8_d), 32'(ereg));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      bit found;
      exp_t e;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_flags", 32'({z, n, v}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000);

      // 1: MOVI/MOVI/ALU LSL1 ADD
      run(CMD_MOVI, 3'd0, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h0007, 16'h0000, 3'b000, 1, 16'h0007);
      run(CMD_MOVI, 3'd1, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h0002, 16'h0000, 3'b000, 1, 16'h0002);
      run(CMD_ALU,  3'd2, 3'd1, 3'd0, SH_LSL1, ALU_ADD, 16'h0000, 16'h0010, 3'b000, 4, 16'h0010);
      // 2: CMP R0,R0
      run(CMD_CMP,  3'd0, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h0000, 16'h0010, 3'b100, 3, 16'h0000);
      check_reg(3'd0, 16'h0007);
      check_reg(3'd1, 16'h0002);
      check_reg(3'd2, 16'h0010);
      // 3: signed overflow on ADD
      run(CMD_MOVI, 3'd3, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h7FFF, 16'h0010, 3'b100, 1, 16'h7FFF);
      run(CMD_MOVI, 3'd4, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h0001, 16'h0010, 3'b100, 1, 16'h0001);
      run(CMD_ALU,  3'd5, 3'd3, 3'd4, SH_NONE, ALU_ADD, 16'h0000, 16'h8000, 3'b011, 4, 16'h8000);
      // 4: MOV with ASR1 then LSR1 (alu_op must be overridden to ADD)
      run(CMD_MOVI, 3'd6, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h8000, 16'h8000, 3'b011, 1, 16'h8000);
      run(CMD_MOV,  3'd7, 3'd0, 3'd6, SH_ASR1, ALU_SUB, 16'h0000, 16'hC000, 3'b010, 3, 16'hC000);
      run(CMD_MOV,  3'd7, 3'd0, 3'd6, SH_LSR1, ALU_ADD, 16'h0000, 16'h4000, 3'b000, 3, 16'h4000);
      // SUB overflow, AND to zero, NOT B, rd==rn==rm
      run(CMD_ALU,  3'd0, 3'd5, 3'd4, SH_NONE, ALU_SUB, 16'h0000, 16'h7FFF, 3'b001, 4, 16'h7FFF);
      run(CMD_ALU,  3'd1, 3'd6, 3'd7, SH_NONE, ALU_AND, 16'h0000, 16'h0000, 3'b100, 4, 16'h0000);
      run(CMD_ALU,  3'd2, 3'd0, 3'd4, SH_LSL1, ALU_NOTB, 16'h0000, 16'hFFFD, 3'b010, 4, 16'hFFFD);
      run(CMD_ALU,  3'd4, 3'd4, 3'd4, SH_NONE, ALU_ADD, 16'h0000, 16'h0002, 3'b000, 4, 16'h0002);

      // 5a: start pulsed while busy is ignored
      issue(CMD_ALU, 3'd5, 3'd4, 3'd4, SH_NONE, ALU_ADD, 16'h0000, 16'h0004, 3'b000, 4);
      @(posedge clk); #1;
      cmd = CMD_MOVI; rd = 3'd6; din = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(nb);
      chk("busy_after_pulse", 32'(nb), 32'd2);
      check_reg(3'd5, 16'h0004);
      check_reg(3'd6, 16'h8000);

      // 5b: start held through done -> back-to-back accept
      @(posedge clk); #1;
      cmd = CMD_ALU; rd = 3'd3; rn = 3'd3; rm = 3'd4; shift = SH_NONE;
      alu_op = ALU_ADD; start = 1'b1;
      e.out = 16'h8001; e.znv = 3'b011; e.lat = 4; e.acc = cyc + 1;
      sb.push_back(e);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin found = 1; break; end
      end
      chk("b2b_first_done", 32'(found), 32'd1);
      e.out = 16'h8003; e.znv = 3'b010; e.lat = 4; e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(nb);
      chk("b2b_busy", 32'(nb), 32'd4);
      check_reg(3'd3, 16'h8003);

      // 5c: reset mid-ALU aborts with no writeback and no done
      @(posedge clk); #1;
      cmd = CMD_ALU; rd = 3'd5; rn = 3'd3; rm = 3'd4; alu_op = ALU_ADD;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_dout", 32'(dout), 32'd0);
      chk("abort_flags", 32'({z, n, v}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000);
      repeat (6) @(negedge clk);
      chk("abort_idle", 32'(busy), 32'd0);

      // 6: 8-bit / 4-register instance
      run8(CMD_MOVI, 2'd0, 2'd0, 2'd0, ALU_ADD, 8'h7F, 8'h00, 3'b000, 8'h7F);
      run8(CMD_MOVI, 2'd1, 2'd0, 2'd0, ALU_ADD, 8'h01, 8'h00, 3'b000, 8'h01);
      run8(CMD_ALU,  2'd2, 2'd0, 2'd1, ALU_ADD, 8'h00, 8'h80, 3'b011, 8'h80);
      run8(CMD_MOVI, 2'd3, 2'd0, 2'd0, ALU_ADD, 8'h55, 8'h80, 3'b011, 8'h55);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
